// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the RF write port between load (port 0) and ALU (port 1) with a starvation bound.
// Define RF_WB_FORWARD_EN to bypass the in-flight write onto the read data outputs.
module rf_wb_arbiter #(
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        rf_en4w,
    output logic [4:0]  rf_addr_w,
    output logic [31:0] rf_data_w,
    input  logic [4:0]  rd_addr0,
    input  logic [4:0]  rd_addr1,
    input  logic [31:0] rf_rdata0,
    input  logic [31:0] rf_rdata1,
    output logic [31:0] fwd_rdata0,
    output logic [31:0] fwd_rdata1
);
    localparam int CW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    logic [CW-1:0] starve_cnt;
    logic          gnt0, gnt1, xfer0, xfer1;
    logic [4:0]    win_addr;
    always_comb begin
        gnt1     = req1_valid & (~req0_valid | (starve_cnt == CW'(STARVE_LIM)));
        gnt0     = req0_valid & ~gnt1;
        xfer0    = gnt0 & ~stall & rst_n;
        xfer1    = gnt1 & ~stall & rst_n;
        win_addr = xfer1 ? req1_addr : req0_addr;
    end
    assign req0_ready = xfer0;
    assign req1_ready = xfer1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (xfer1 || !req1_valid)
            starve_cnt <= '0;
        else if (xfer0 && starve_cnt != CW'(STARVE_LIM))
            starve_cnt <= starve_cnt + 1'b1;
    end
    // x0 writes are accepted but never raise the enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_en4w   <= 1'b0;
            rf_addr_w <= '0;
            rf_data_w <= '0;
        end else if (xfer0 || xfer1) begin
            rf_en4w   <= win_addr != 5'd0;
            rf_addr_w <= win_addr;
            rf_data_w <= xfer1 ? req1_data : req0_data;
        end else
            rf_en4w <= 1'b0;
    end
`ifdef RF_WB_FORWARD_EN
    assign fwd_rdata0 = (rf_en4w && rd_addr0 == rf_addr_w && rd_addr0 != 5'd0) ? rf_data_w : rf_rdata0;
    assign fwd_rdata1 = (rf_en4w && rd_addr1 == rf_addr_w && rd_addr1 != 5'd0) ? rf_data_w : rf_rdata1;
`else
    logic rd_unused;
    assign rd_unused  = ^{rd_addr0, rd_addr1};
    assign fwd_rdata0 = rf_rdata0;
    assign fwd_rdata1 = rf_rdata1;
`endif
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back arbiter for the 3-port register file (1 write, 2 read; x0 hard-wired to zero). Shares the single write port between two requesters, the load unit (port 0) and the ALU/execute result (port 1), using valid/ready handshakes. Port 0 has fixed priority; a starvation counter bounds how long port 1 can be held off. A registered write stage drives the register file's write enable, address and data.

Parameters:
STARVE_LIM, 4, max consecutive port-0 transfers while port 1 is waiting; 0 = port 1 always wins when valid.

Ports:
clk  in  1  clock; all state on posedge.
rst_n  in  1  asynchronous, active-low reset.
stall  in  1  when high, no request is accepted.
req0_valid  in  1  port 0 (load) write request.
req0_ready  out  1  port 0 accept.
req0_addr  in  5  port 0 destination register.
req0_data  in  32  port 0 write data.
req1_valid  in  1  port 1 (ALU) write request.
req1_ready  out  1  port 1 accept.
req1_addr  in  5  port 1 destination register.
req1_data  in  32  port 1 write data.
rf_en4w  out  1  register-file write enable.
rf_addr_w  out  5  register-file write address.
rf_data_w  out  32  register-file write data.
rd_addr0, rd_addr1  in  5 each  register-file read addresses (as driven to the RF).
rf_rdata0, rf_rdata1  in  32 each  raw register-file read data.
fwd_rdata0, fwd_rdata1  out  32 each  read data delivered to consumers.

Behaviour:
- Transfer on a port = valid & ready in the same cycle. Requesters hold valid, addr and data stable until the transfer.
- Grant logic is combinational:
  - gnt1 = req1_valid & (~req0_valid | starve_cnt == STARVE_LIM).
  - gnt0 = req0_valid & ~gnt1.
  - reqN_ready = gntN & ~stall.
  - At most one ready is high per cycle. Ready never asserts without the matching valid.
- starve_cnt has width max(1, clog2(STARVE_LIM+1)) and resets to 0. On each posedge:
  - port-1 transfer, or req1_valid low: cleared to 0.
  - port-0 transfer while req1_valid high: incremented, saturating at STARVE_LIM.
  - otherwise: held.
- Write stage registers (rf_en4w, rf_addr_w, rf_data_w) reset to 0. On each posedge:
  - on a transfer: rf_addr_w and rf_data_w load the winner's addr and data; rf_en4w <= (addr != 0).
  - with no transfer: rf_en4w <= 0; addr and data hold.
- Latency: request accepted at edge N → rf_en4w high during cycle N+1 → RF captures at edge N+1. Sustained throughput is 1 write per cycle.
- Writes to x0 are accepted (ready asserted, counter updated) but never produce rf_en4w.
- stall high: both readys low and starve_cnt holds. The write stage still drains its in-flight entry (rf_en4w for that entry stays high for its one cycle).
- Reset asserted mid-operation: all registers clear immediately (asynchronously); any in-flight write is dropped; readys are low while rst_n is low.
- Simultaneous valid on both ports with the counter below the limit: port 0 wins and port 1 waits. Once STARVE_LIM port-0 wins have accumulated, port 1 wins the next cycle.

Optional Feature:
Macro RF_WB_FORWARD_EN.
- Defined: fwd_rdataX = rf_data_w when rf_en4w & (rd_addrX == rf_addr_w) & (rd_addrX != 0); otherwise rf_rdataX. This closes the same-cycle write/read hazard on the register file.
- Undefined: fwd_rdataX = rf_rdataX, a pure passthrough. The ports exist in both builds.

Test Plan:
- Reset: rst_n low → all outputs 0, both readys 0; release with req1_valid=1, addr 5, data 0xA5A5A5A5 → req1_ready=1, then rf_en4w=1, rf_addr_w=5, rf_data_w=0xA5A5A5A5 for one cycle.
- Contention with STARVE_LIM=4: both valid continuously → grant order is port 0 ×4, then port 1 ×1, repeating; no cycle has both readys high.
- x0 write: req0 addr 0, data 0xDEADBEEF → req0_ready=1, rf_en4w stays 0 next cycle.
- Stall: stall=1 for 3 cycles with both valid → readys 0, starve_cnt unchanged; an already-accepted write still appears on rf_en4w in the first stall cycle.
- Async reset mid-transfer: assert rst_n low between edges while rf_en4w=1 → rf_en4w drops to 0 immediately, without a clock edge.
- Forwarding (RF_WB_FORWARD_EN defined): rf_en4w=1, rf_addr_w=7, rf_data_w=0x12345678, rd_addr0=7, rf_rdata0=0 → fwd_rdata0=0x12345678. With rd_addr0=0 → fwd_rdata0=rf_rdata0. With the macro undefined → always rf_rdata0.
